// File: rtl/shift_rotate_pkg.sv
// Shared types for the pipelined shift/rotate unit: operation modes and the
// per-stage payload that travels down the pipe alongside each operation.
package shift_rotate_pkg;

    // Default operand geometry; the payload struct is sized from these, so the
    // top-level WIDTH/TAG_W defaults must track them.
    localparam int SR_WIDTH = 32;
    localparam int SR_TAG_W = 4;
    localparam int SR_AW    = $clog2(SR_WIDTH);

    typedef enum logic [1:0] {
        MODE_SHR  = 2'b00,
        MODE_ROTR = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SAR  = 2'b11
    } sr_mode_e;

    typedef struct packed {
        logic [SR_WIDTH-1:0] data;
        logic [SR_AW-1:0]    amount;
        sr_mode_e            mode;
        logic [SR_TAG_W-1:0] tag;
        logic                sign;
    } sr_payload_t;

endpackage

// File: rtl/shift_rotate_stage.sv
// One pipeline stage: conditionally moves the operand by 2^STAGE according to
// the mode, then registers the payload when the stage is allowed to load.
module shift_rotate_stage
    import shift_rotate_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        valid_i,
    input  sr_payload_t payload_i,
    output logic        valid_o,
    output sr_payload_t payload_o
);

    localparam int DIST = 1 << STAGE;

    logic                valid_q;
    sr_payload_t         payload_q;
    sr_payload_t         payload_d;
    logic [SR_WIDTH-1:0] moved;

    // SAR fills from the operand's original MSB, captured once at entry.
    always_comb begin
        payload_d = payload_i;
        case (payload_i.mode)
            MODE_SHR:  moved = payload_i.data >> DIST;
            MODE_SHL:  moved = payload_i.data << DIST;
            MODE_SAR:  moved = (payload_i.data >> DIST)
                             | ({SR_WIDTH{payload_i.sign}} << (SR_WIDTH - DIST));
            MODE_ROTR: moved = (payload_i.data >> DIST)
                             | (payload_i.data << (SR_WIDTH - DIST));
            default:   moved = payload_i.data;
        endcase
        if (payload_i.amount[STAGE]) begin
            payload_d.data = moved;
        end
    end

    // Bubbles move the valid bit only, so held results and the post-reset
    // output value are not disturbed by don't-care input data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                payload_q <= payload_d;
            end
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined run-time shift/rotate unit with valid/ready flow control, bubble
// collapse and a passthrough tag; AW stages, one result per clock.
module shift_rotate_pipe
    import shift_rotate_pkg::*;
#(
    parameter int  WIDTH = SR_WIDTH,
    parameter int  TAG_W = SR_TAG_W,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amount,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [AW-1:0] stage_valid;
    logic [AW-1:0] stage_vin;
    logic [AW-1:0] advance;
    sr_payload_t   stage_in  [AW];
    sr_payload_t   stage_out [AW];
    sr_payload_t   head;
    logic          unused_last_fields;

    always_comb begin
        head.data   = in_data;
        head.amount = in_amount;
        head.mode   = sr_mode_e'(in_mode);
        head.tag    = in_tag;
        head.sign   = in_data[WIDTH-1];
    end

    // A stage loads when empty or when its successor loads; the last stage
    // follows out_ready, which makes out_ready -> in_ready combinational.
    always_comb begin
        advance = '0;
        for (int k = AW - 1; k >= 0; k--) begin
            if (k == AW - 1) begin
                advance[k] = ~stage_valid[k] | out_ready;
            end else begin
                advance[k] = ~stage_valid[k] | advance[k+1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_vin[gi] = in_valid;
                assign stage_in[gi]  = head;
            end else begin : g_link
                assign stage_vin[gi] = stage_valid[gi-1];
                assign stage_in[gi]  = stage_out[gi-1];
            end

            shift_rotate_stage #(
                .STAGE (gi)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .load_i    (advance[gi]),
                .valid_i   (stage_vin[gi]),
                .payload_i (stage_in[gi]),
                .valid_o   (stage_valid[gi]),
                .payload_o (stage_out[gi])
            );
        end
    endgenerate

    assign in_ready  = advance[0];
    assign out_valid = stage_valid[AW-1];
    assign out_data  = stage_out[AW-1].data;
    assign out_tag   = stage_out[AW-1].tag;

    assign unused_last_fields = ^{stage_out[AW-1].amount, stage_out[AW-1].mode,
                                  stage_out[AW-1].sign};

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed and scoreboarded checks of shift_rotate_pipe at WIDTH=32, TAG_W=4.
module tb_shift_rotate_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amount = '0;
    logic [1:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_rotate_pipe #(
        .WIDTH (32),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] mode, input logic [4:0] amt,
                                           input logic [31:0] d);
        int a;
        a = int'(amt);
        case (mode)
            2'b00:   return d >> a;
            2'b01:   return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
            2'b10:   return d << a;
            default: return 32'($signed(d) >>> a);
        endcase
    endfunction

    // Single operation with out_ready held high; checks latency, data and tag.
    task automatic run_op(input string name, input logic [1:0] m, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] t, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_amount = a;
        in_data   = d;
        in_tag    = t;
        #1;
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd5);
        check({name, " data"}, out_data, exp);
        check({name, " tag"}, {28'd0, out_tag}, {28'd0, t});
        $display("op %s mode=%0d amt=%0d data=%h -> %h tag=%0d", name, m, a, d, out_data, out_tag);
    endtask

    logic [35:0] sb[$];
    logic [35:0] e;
    int          acc;
    int          seen;
    logic [3:0]  seq;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset out_tag", {28'd0, out_tag}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Directed single operations
        run_op("shr4",    2'b00, 5'd4,  32'h8000_00F0, 4'h1, 32'h0800_000F);
        run_op("rotr7",   2'b01, 5'd7,  32'h0000_0081, 4'h2, 32'h0200_0001);
        run_op("rotr31",  2'b01, 5'd31, 32'h0000_0001, 4'h3, 32'h0000_0002);
        run_op("sar31",   2'b11, 5'd31, 32'h8000_0000, 4'h4, 32'hFFFF_FFFF);
        run_op("shl1",    2'b10, 5'd1,  32'h8000_0001, 4'h5, 32'h0000_0002);
        run_op("shr0",    2'b00, 5'd0,  32'hDEAD_BEEF, 4'h6, 32'hDEAD_BEEF);
        run_op("rotr0",   2'b01, 5'd0,  32'hDEAD_BEEF, 4'h7, 32'hDEAD_BEEF);
        run_op("shl0",    2'b10, 5'd0,  32'hDEAD_BEEF, 4'h8, 32'hDEAD_BEEF);
        run_op("sar0",    2'b11, 5'd0,  32'hDEAD_BEEF, 4'h9, 32'hDEAD_BEEF);
        run_op("sar3pos", 2'b11, 5'd3,  32'h7000_0008, 4'hA, 32'h0E00_0001);

        // Stall: ops are ROTR 4 of 0x12345670+i, so result is {i, 28'h1234567}
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 8; c++) begin
            in_valid  = 1'b1;
            in_mode   = 2'b01;
            in_amount = 5'd4;
            in_data   = 32'h1234_5670 + 32'(acc);
            in_tag    = 4'(acc);
            #1;
            if (!in_ready) break;
            acc++;
            @(negedge clk);
        end
        check("stall accepted before full", 32'(acc), 32'd5);
        for (int h = 0; h < 3; h++) begin
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
            check("stall out_valid", {31'd0, out_valid}, 32'd1);
            check("stall out_data", out_data, {4'h0, 28'h1234567});
            check("stall out_tag", {28'd0, out_tag}, 32'd0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (acc < 8) begin
                in_valid = 1'b1;
                in_data  = 32'h1234_5670 + 32'(acc);
                in_tag   = 4'(acc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("drain out_valid", {31'd0, out_valid}, 32'd1);
            check("drain out_tag", {28'd0, out_tag}, 32'(c));
            check("drain out_data", out_data, {4'(c), 28'h1234567});
            $display("drain tag=%0d data=%h", out_tag, out_data);
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stall all accepted", 32'(acc), 32'd8);

        // Reset mid-flight with three operations in the pipe
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_mode   = 2'b10;
            in_amount = 5'd1;
            in_data   = 32'h0000_1111 << i;
            in_tag    = 4'(9 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst out_data", out_data, 32'd0);
        check("midrst out_tag", {28'd0, out_tag}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst nothing emerges", 32'(seen), 32'd0);
        $display("reset mid-flight: %0d stale results observed", seen);

        // Random stream: random backpressure, then a saturated phase, then drain
        seq = 4'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c < 300) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (c < 360) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_mode   = 2'($urandom);
            in_amount = 5'($urandom);
            in_data   = $urandom;
            in_tag    = seq;
            #1;
            if (c >= 305 && c < 360) begin
                check("thru in_ready", {31'd0, in_ready}, 32'd1);
                check("thru out_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand unexpected result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rand data", out_data, e[31:0]);
                    check("rand tag", {28'd0, out_tag}, {28'd0, e[35:32]});
                    $display("rand tag=%0d data=%h", out_tag, out_data);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_tag, ref_op(in_mode, in_amount, in_data)});
                seq++;
            end
        end
        check("rand drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
